psum_drain: RTL and testbench

//   Read-out end of the partial-sum accumulators. Snapshots one column of DEPTH signed

---
 rtl/psum_drain.sv | 138 +++++++++++++
 tb/tb_psum_drain.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: snapshots DEPTH signed partial sums and streams them out one per beat, narrowed to OWIDTH.
// Latency: first beat is valid the cycle after an accepted load; one beat per cycle while i_ready is high.
// Backpressure: beat is held stable while o_valid & ~i_ready; a load that arrives mid-drain is dropped (o_drop).
// Build option: define PSUM_DRAIN_SAT_EN to saturate entries into OWIDTH instead of truncating them.
module psum_drain #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int OWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic [DEPTH*WIDTH-1:0]   i_psum,
  output logic                     o_busy,
  output logic                     o_drop,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OWIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_last,
  output logic                     o_sat
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q [DEPTH];

  logic             load_acc;   // snapshot taken this cycle
  logic             advance;    // non-final beat leaves this cycle
  logic             drop_d;     // load rejected this cycle
  logic [IW-1:0]    idx_inc;
  logic [WIDTH-1:0] src;        // entry feeding the next registered beat
  logic [OWIDTH-1:0] nar_data;
  logic             nar_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake decode; a load is only accepted when the buffer is free
  // or its last beat is leaving in the same cycle (back-to-back without a bubble)
  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    advance  = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          load_acc = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (i_ready && (o_idx == LAST_IDX)) begin
          if (i_load) load_acc = 1'b1;
          else        state_d  = IDLE;
        end else begin
          advance = i_ready;
          drop_d  = i_load;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_valid = (state_q == DRAIN);
  assign o_busy  = (state_q == DRAIN);

  // Next entry: entry 0 of the incoming snapshot on a load, otherwise the following buffered entry
  always_comb begin
    idx_inc = (o_idx == LAST_IDX) ? '0 : o_idx + 1'b1;
    src     = load_acc ? i_psum[WIDTH-1:0] : buf_q[idx_inc];
  end

`ifdef PSUM_DRAIN_SAT_EN
  logic [WIDTH-OWIDTH:0] src_hi;
  assign src_hi = src[WIDTH-1:OWIDTH-1];

  // Signed saturation: the value fits only if every bit above the output sign bit matches it
  always_comb begin
    nar_data = src[OWIDTH-1:0];
    nar_sat  = 1'b0;
    if (!((&src_hi) || !(|src_hi))) begin
      nar_sat  = 1'b1;
      nar_data = src[WIDTH-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    end
  end
`else
  logic src_unused;
  assign nar_data   = src[OWIDTH-1:0];
  assign nar_sat    = 1'b0;
  assign src_unused = ^src;
`endif

  // Snapshot buffer: captures the whole column when a load is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) buf_q[k] <= '0;
    end else if (load_acc) begin
      for (int k = 0; k < DEPTH; k++) buf_q[k] <= i_psum[k*WIDTH +: WIDTH];
    end
  end

  // Output beat registers: only move on a load or a transfer, so they hold under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_data <= '0;
      o_idx  <= '0;
      o_last <= 1'b0;
      o_sat  <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      o_drop <= drop_d;
      if (load_acc) begin
        o_idx  <= '0;
        o_data <= nar_data;
        o_sat  <= nar_sat;
        o_last <= 1'b0;
      end else if (advance) begin
        o_idx  <= idx_inc;
        o_data <= nar_data;
        o_sat  <= nar_sat;
        o_last <= (idx_inc == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: scoreboard bench for psum_drain with WIDTH=32, DEPTH=4, OWIDTH=16.
// Expected beats are queued when a load is driven and popped as the sink accepts beats.
// Honours PSUM_DRAIN_SAT_EN for the expected saturation/truncation results.
module tb_psum_drain;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int OW = 16;
  localparam int IW = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          i_load  = 1'b0;
  logic          i_ready = 1'b0;
  logic [D*W-1:0] i_psum = '0;
  logic          o_busy, o_drop, o_valid, o_last, o_sat;
  logic [OW-1:0] o_data;
  logic [IW-1:0] o_idx;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
    logic          sat;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  psum_drain #(.WIDTH(W), .DEPTH(D), .OWIDTH(OW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (i_load),
    .i_psum  (i_psum),
    .o_busy  (o_busy),
    .o_drop  (o_drop),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_idx   (o_idx),
    .o_last  (o_last),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference beat for entry k holding signed value v
  function automatic beat_t model(input int v, input int k);
    beat_t b;
    int    c;
    c     = v;
    b.sat = 1'b0;
`ifdef PSUM_DRAIN_SAT_EN
    if (v > 32767) begin
      c     = 32767;
      b.sat = 1'b1;
    end else if (v < -32768) begin
      c     = -32768;
      b.sat = 1'b1;
    end
`endif
    b.data = c[15:0];
    b.idx  = IW'(k);
    b.last = (k == D - 1);
    return b;
  endfunction

  // Drive a one-cycle load starting just after a rising edge; queue expectations if it should be accepted
  task automatic do_load(input int a, input int b, input int c, input int d, input bit push);
    int e[4];
    e = '{a, b, c, d};
    for (int k = 0; k < D; k++) begin
      i_psum[k*W +: W] = e[k];
      if (push) sb.push_back(model(e[k], k));
    end
    i_load = 1'b1;
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!o_busy) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", o_busy, 0);
  endtask

  // Scoreboard monitor: a beat is consumed when valid & ready are seen outside reset
  always @(negedge clk) begin
    beat_t exp;
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        exp = sb.pop_front();
        chk("beat_data", o_data, exp.data);
        chk("beat_idx",  o_idx,  exp.idx);
        chk("beat_last", o_last, exp.last);
        chk("beat_sat",  o_sat,  exp.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy",  o_busy,  0);
    chk("rst_data",  o_data,  0);
    chk("rst_idx",   o_idx,   0);
    chk("rst_drop",  o_drop,  0);
    chk("rst_last",  o_last,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain stream with the sink always ready
    i_ready = 1'b1;
    do_load(10, -5, 300, 7, 1'b1);
    chk("stream_valid_c1", o_valid, 1);
    chk("stream_data_c1",  o_data,  16'd10);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_busy_c5",  o_busy,  0);
    chk("stream_valid_c5", o_valid, 0);

    // Backpressure on beat 1 for three cycles
    do_load(10, -5, 300, 7, 1'b1);
    @(posedge clk); #1;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data",  o_data,  16'hFFFB);
      chk("bp_idx",   o_idx,   1);
      chk("bp_valid", o_valid, 1);
      @(posedge clk); #1;
    end
    chk("bp_data_after", o_data, 16'hFFFB);
    i_ready = 1'b1;
    wait_idle();

    // Overrun mid-drain, then back-to-back load on the last beat
    do_load(1, 2, 3, 4, 1'b1);
    @(posedge clk); #1;
    do_load(100, 200, 300, 400, 1'b0);
    chk("drop_pulse", o_drop, 1);
    @(posedge clk); #1;
    chk("drop_clear", o_drop, 0);
    chk("drop_idx",   o_idx,  3);
    do_load(11, 22, 33, 44, 1'b1);
    chk("b2b_valid", o_valid, 1);
    chk("b2b_idx",   o_idx,   0);
    chk("b2b_data",  o_data,  16'd11);
    chk("b2b_drop",  o_drop,  0);
    wait_idle();

    // Saturation / truncation boundaries
    do_load(70000, -70000, 32767, -32768, 1'b1);
    wait_idle();

    // Reset during beat 2, then a fresh load
    do_load(5, 6, 7, 8, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("mr_idx_before", o_idx, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk("mr_valid", o_valid, 0);
    chk("mr_busy",  o_busy,  0);
    chk("mr_idx",   o_idx,   0);
    chk("mr_data",  o_data,  0);
    do_load(9, -9, 9, -9, 1'b1);
    chk("mr_fresh_idx",  o_idx,  0);
    chk("mr_fresh_data", o_data, 16'd9);
    wait_idle();

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
